trace_uart_tx: RTL and testbench

- Retirement-trace serializer downstream of the single-clock RISC-V core in `top`.
- Consumes one trace record (pc, instruction word, selected register value) per retired instruction.
- Buffers records in a small FIFO and streams each one as a fixed byte frame over a UART 8N1 line.
- Gives board-level visibility of the same pc / instruction / x10 stream the simulation prints.

---
 rtl/trace_uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_trace_uart_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_uart_tx.sv
// rtl/trace_uart_tx.sv - retirement-trace FIFO plus UART 8N1 frame serializer
// Define TRACE_UART_CHECKSUM_EN to append an XOR checksum byte to every frame.
module trace_uart_tx #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_instr,
  input  logic [31:0] trace_reg,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CNT_LAST = 16'(BAUD_DIV - 1);
`ifdef TRACE_UART_CHECKSUM_EN
  localparam logic [3:0]  LAST_BYTE = 4'd13;
`else
  localparam logic [3:0]  LAST_BYTE = 4'd12;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t       state_q;
  logic [15:0]  cnt_q;
  logic [2:0]   bit_idx_q;
  logic [3:0]   byte_idx_q;
  logic [95:0]  frame_q;
  logic         tx_q;
  logic         overflow_q;
  logic [7:0]   drop_cnt_q;

  logic [95:0]  mem_q [FIFO_DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  logic         fifo_empty, fifo_full;
  logic         bit_end, frame_done;
  logic         pop, push, drop;
  logic [95:0]  head;
  logic [7:0]   cur_byte;

  // The extra pointer MSB separates a full ring from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign bit_end    = (cnt_q == CNT_LAST);
  assign frame_done = (state_q == STOP) && bit_end && (byte_idx_q == LAST_BYTE);
  assign pop        = !fifo_empty && ((state_q == IDLE) || frame_done);
  assign push       = trace_valid && (!fifo_full || pop);
  assign drop       = trace_valid && fifo_full && !pop;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

`ifdef TRACE_UART_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < 12; i++) begin
      csum = csum ^ frame_q[8*i +: 8];
    end
  end
`endif

  // Byte 0 is the sync marker; payload bytes follow pc, instr, reg MSB first.
  always_comb begin
    cur_byte = SYNC_BYTE;
    for (int k = 1; k <= 12; k++) begin
      if (byte_idx_q == 4'(k)) cur_byte = frame_q[103-8*k -: 8];
    end
`ifdef TRACE_UART_CHECKSUM_EN
    if (byte_idx_q == 4'd13) cur_byte = csum;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {trace_pc, trace_instr, trace_reg};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      frame_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            frame_q    <= head;
            byte_idx_q <= '0;
            cnt_q      <= '0;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_q + 4'd1;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else if (pop) begin
              // Next record goes straight out with no idle gap.
              frame_q    <= head;
              byte_idx_q <= '0;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// tb/tb_trace_uart_tx.sv - directed self-checking bench for trace_uart_tx
// Decodes the UART line bit by bit with BAUD_DIV=4 and FIFO_DEPTH=4.
module tb_trace_uart_tx;

  localparam int BD = 4;
`ifdef TRACE_UART_CHECKSUM_EN
  localparam int NB = 14;
`else
  localparam int NB = 13;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trace_valid = 1'b0;
  logic [31:0] trace_pc = '0;
  logic [31:0] trace_instr = '0;
  logic [31:0] trace_reg = '0;
  logic        tx, busy, overflow;
  logic [7:0]  drop_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = -1;
  logic busy_last = 1'b0;

  logic [7:0]  exp_single [14];
  logic [31:0] r_pc [6];
  logic [31:0] r_in [6];
  logic [31:0] r_rg [6];

  trace_uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .trace_valid(trace_valid),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_reg(trace_reg),
    .tx(tx), .busy(busy), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy_last && !busy) fall_cyc = cyc;
    busy_last = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input logic [31:0] pc, input logic [31:0] ins,
                                       input logic [31:0] rg, input int k);
    logic [103:0] f;
    logic [7:0]   x;
    f = {8'hA5, pc, ins, rg};
    if (k == 13) begin
      x = 8'h00;
      for (int i = 1; i <= 12; i++) x = x ^ 8'(f >> (8 * (12 - i)));
      return x;
    end
    return 8'(f >> (8 * (12 - k)));
  endfunction

  // Entered at the negedge holding the first sample of a start bit.
  task automatic rx_byte(output logic [7:0] b, output bit ok);
    logic v;
    ok = 1'b1;
    b  = 8'h00;
    for (int i = 0; i < 10; i++) begin
      v = tx;
      for (int j = 0; j < BD; j++) begin
        if (tx !== v) ok = 1'b0;
        @(negedge clk);
      end
      if (i == 0 && v !== 1'b0) ok = 1'b0;
      if (i == 9 && v !== 1'b1) ok = 1'b0;
      if (i >= 1 && i <= 8) b[i-1] = v;
    end
  endtask

  task automatic rx_frame(input string tag, input int r);
    logic [7:0] b;
    bit ok, all_ok;
    all_ok = 1'b1;
    for (int k = 0; k < NB; k++) begin
      rx_byte(b, ok);
      all_ok &= ok;
      check(tag, b, fbyte(r_pc[r], r_in[r], r_rg[r], k));
    end
    check({tag, "_bits"}, all_ok, 1);
  endtask

  initial begin
    logic [7:0] b;
    bit ok, all_ok;
    int c0, zeros;

    exp_single = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'hA0, 8'h05,
                   8'h13, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hB8};
    for (int i = 0; i < 6; i++) begin
      r_pc[i] = 32'h01020300 + i;
      r_in[i] = 32'h80000013 ^ (i << 8);
      r_rg[i] = 32'h11111111 * (i + 1);
    end

    // reset held with trace_valid toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      trace_valid = ~trace_valid;
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      check("rst_drop", drop_count, 0);
    end
    @(negedge clk);
    trace_valid = 1'b0;
    rst = 1'b1;
    zeros = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) zeros++;
    end
    check("post_rst_idle", zeros, 0);

    // single frame
    trace_pc = 32'h00000004; trace_instr = 32'h00A00513; trace_reg = 32'h0000000A;
    trace_valid = 1'b1;
    @(negedge clk);
    trace_valid = 1'b0;
    check("pre_start_tx", tx, 1);
    @(negedge clk);
    c0 = cyc;
    check("start_busy", busy, 1);
    all_ok = 1'b1;
    for (int k = 0; k < NB; k++) begin
      rx_byte(b, ok);
      all_ok &= ok;
      check("single_byte", b, exp_single[k]);
    end
    check("single_bits", all_ok, 1);
    @(negedge clk);
    check("single_busy_fall", fall_cyc - c0, NB * 10 * BD);
    check("single_busy_end", busy, 0);

    // back-to-back: pushes at edges N and N+2
    fork
      begin
        trace_pc = r_pc[0]; trace_instr = r_in[0]; trace_reg = r_rg[0]; trace_valid = 1'b1;
        @(negedge clk);
        trace_valid = 1'b0;
        @(negedge clk);
        trace_pc = r_pc[1]; trace_instr = r_in[1]; trace_reg = r_rg[1]; trace_valid = 1'b1;
        @(negedge clk);
        trace_valid = 1'b0;
      end
    join_none
    @(negedge clk);
    @(negedge clk);
    rx_frame("b2b_f0", 0);
    rx_frame("b2b_f1", 1);
    check("b2b_idle_tx", tx, 1);

    // overflow: six consecutive pushes into a four-deep FIFO
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          trace_pc = r_pc[i]; trace_instr = r_in[i]; trace_reg = r_rg[i]; trace_valid = 1'b1;
          @(negedge clk);
        end
        trace_valid = 1'b0;
      end
    join_none
    @(negedge clk);
    @(negedge clk);
    for (int r = 0; r < 5; r++) rx_frame("ovf_frame", r);
    zeros = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1) zeros++;
      @(negedge clk);
    end
    check("ovf_no_sixth", zeros, 0);
    check("ovf_busy", busy, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_drop", drop_count, 1);

    // reset during byte 5 data bits
    fork
      begin
        trace_pc = 32'h00000004; trace_instr = 32'h00A00513; trace_reg = 32'h0000000A;
        trace_valid = 1'b1;
        @(negedge clk);
        trace_valid = 1'b0;
      end
    join_none
    @(negedge clk);
    @(negedge clk);
    repeat (5 * 10 * BD + BD + 2) @(negedge clk);
    check("mid_data_tx", tx, 0);
    check("mid_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_drop", drop_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) zeros++;
    end
    check("mid_after_idle", zeros, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
